// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer blocks.
//   ADDR_WIDTH : default pointer/address width
//   DEPTH      : storage depth (2**ADDR_WIDTH)
//   CAPACITY   : usable slots; one slot is sacrificed so full and empty differ
//   ptr_inc    : wrapping pointer increment for any width up to 31 bits
package fifo_pkg;

  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned DEPTH      = 32'd1 << ADDR_WIDTH;
  localparam int unsigned CAPACITY   = DEPTH - 32'd1;

  // Increment ptr by one and wrap it to a width-bit pointer.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned width);
    int unsigned mask;
    mask = (32'd1 << width) - 32'd1;
    return (ptr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/fifo_level.sv
// Combinational occupancy from a write/read pointer pair.
//   wptr  : write pointer
//   rptr  : read pointer
//   level : (wptr - rptr) mod 2**ADDR_WIDTH
module fifo_level #(
  parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] wptr,
  input  logic [ADDR_WIDTH-1:0] rptr,
  output logic [ADDR_WIDTH-1:0] level
);

  // Same-width subtraction gives the modular distance directly.
  assign level = wptr - rptr;

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer and full detection for the binary-pointer synchronous FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : write request this cycle
//   rptr        : read pointer from the read-side block
//   ovf_clr     : clears the sticky overflow flag
//   wptr        : next slot to be written (registered)
//   mem_we      : array write strobe (combinational)
//   mem_waddr   : array write address (combinational, equals wptr)
//   full        : no free slot (combinational)
//   almost_full : fill level at or above AF_THRESH (registered)
//   fill_level  : occupied slots (combinational)
//   overflow    : sticky, a write was attempted while full (registered)
module wptr_full #(
  parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int unsigned AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] rptr,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH-1:0] wptr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH-1:0] fill_level,
  output logic                  overflow
);

  import fifo_pkg::ptr_inc;

  logic [ADDR_WIDTH-1:0] wptr_inc_c;
  logic [ADDR_WIDTH-1:0] wptr_next_c;
  logic [ADDR_WIDTH-1:0] level_next_c;
  logic                  wr_reject_c;

  // Full when one more write would make the pointers equal (the empty condition).
  assign wptr_inc_c  = ADDR_WIDTH'(ptr_inc(32'(wptr), ADDR_WIDTH));
  assign full        = (wptr_inc_c == rptr);
  assign mem_we      = wr_en && !full;
  assign mem_waddr   = wptr;
  assign wr_reject_c = wr_en && full;
  assign wptr_next_c = mem_we ? wptr_inc_c : wptr;

  // Current occupancy, reported directly.
  fifo_level #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_level (
    .wptr  (wptr),
    .rptr  (rptr),
    .level (fill_level)
  );

  // Post-write occupancy against the pre-read rptr; feeds the almost_full register.
  fifo_level #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_level_next (
    .wptr  (wptr_next_c),
    .rptr  (rptr),
    .level (level_next_c)
  );

  // Pointer, threshold flag and sticky overflow; a rejected write beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wptr        <= wptr_next_c;
      almost_full <= (32'(level_next_c) >= AF_THRESH);
      if (wr_reject_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (ADDR_WIDTH=4, AF_THRESH=12).
// Reference model: a queue holding the addresses of stored entries plus
// independent modulo-16 pointer counters.
module tb_wptr_full;

  localparam int unsigned AW  = 4;
  localparam int          DEP = 16;
  localparam int          CAP = 15;
  localparam int          AFT = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] rptr;
  logic          ovf_clr;
  logic [AW-1:0] wptr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          full;
  logic          almost_full;
  logic [AW-1:0] fill_level;
  logic          overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  int q[$];
  int wp_m;
  int rp_m;
  bit ovf_m;
  bit af_m;
  bit rd_req;

  always #5 clk = ~clk;

  wptr_full #(
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AFT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .rptr        (rptr),
    .ovf_clr     (ovf_clr),
    .wptr        (wptr),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .full        (full),
    .almost_full (almost_full),
    .fill_level  (fill_level),
    .overflow    (overflow)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    q.delete();
    wp_m  = 0;
    rp_m  = 0;
    ovf_m = 1'b0;
    af_m  = 1'b0;
  endtask

  // Called just after a negedge: drive this cycle's request and let it settle.
  task automatic pre_edge(input bit wr, input bit rd, input bit clr);
    wr_en   = wr;
    ovf_clr = clr;
    rd_req  = rd;
    #1;
  endtask

  // Clock edge plus model update; the read side advances rptr after the edge.
  task automatic post_edge();
    bit was_full;
    int pre_size;
    @(posedge clk);
    pre_size = q.size();
    was_full = (pre_size == CAP);
    if (wr_en && was_full) ovf_m = 1'b1;
    else if (ovf_clr)      ovf_m = 1'b0;
    if (wr_en && !was_full) begin
      q.push_back(wp_m);
      wp_m = (wp_m + 1) % DEP;
    end
    af_m = (q.size() >= AFT);
    if (rd_req && pre_size > 0) begin
      void'(q.pop_front());
      rp_m = (rp_m + 1) % DEP;
    end
    #1;
    rptr    = AW'(rp_m);
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    rd_req  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; ovf_clr = 1'b0; rd_req = 1'b0; rptr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (wptr !== 4'd0) begin tests_failed++; $display("FAIL reset_wptr: got %0d expected 0", wptr); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %0b expected 0", full); end
    tests_run++; if (fill_level !== 4'd0) begin tests_failed++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
    tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL reset_af: got %0b expected 0", almost_full); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
    repeat (7) begin pre_edge(1'b1, 1'b0, 1'b0); post_edge(); end
    tests_run++; if (wptr !== 4'd7) begin tests_failed++; $display("FAIL burst_wptr: got %0d expected 7", wptr); end
    // Reset asserted mid-cycle with a write still requested.
    pre_edge(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++; if (wptr !== 4'd0) begin tests_failed++; $display("FAIL midreset_wptr: got %0d expected 0", wptr); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL midreset_ovf: got %0b expected 0", overflow); end
    tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL midreset_af: got %0b expected 0", almost_full); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL midreset_full: got %0b expected 0", full); end
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < CAP; i++) begin
      pre_edge(1'b1, 1'b0, 1'b0);
      tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL fill_we[%0d]: got %0b expected 1", i, mem_we); end
      tests_run++; if (mem_waddr !== AW'(i)) begin tests_failed++; $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, mem_waddr, i); end
      post_edge();
      tests_run++; if (almost_full !== (i + 1 >= AFT)) begin tests_failed++; $display("FAIL fill_af[%0d]: got %0b expected %0b", i, almost_full, (i + 1 >= AFT)); end
    end
    tests_run++; if (wptr !== 4'd15) begin tests_failed++; $display("FAIL fill_wptr: got %0d expected 15", wptr); end
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fill_full: got %0b expected 1", full); end
    tests_run++; if (fill_level !== 4'd15) begin tests_failed++; $display("FAIL fill_level: got %0d expected 15", fill_level); end
  endtask

  task automatic test_overflow();
    pre_edge(1'b1, 1'b0, 1'b0);
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL ovf_we: got %0b expected 0", mem_we); end
    post_edge();
    tests_run++; if (wptr !== 4'd15) begin tests_failed++; $display("FAIL ovf_wptr: got %0d expected 15", wptr); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
    pre_edge(1'b0, 1'b0, 1'b1);
    post_edge();
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clr: got %0b expected 0", overflow); end
  endtask

  task automatic test_wrap();
    int exp_addr[4];
    exp_addr = '{14, 15, 0, 1};
    do_reset();
    repeat (3)  begin pre_edge(1'b1, 1'b0, 1'b0); post_edge(); end
    repeat (3)  begin pre_edge(1'b0, 1'b1, 1'b0); post_edge(); end
    repeat (11) begin pre_edge(1'b1, 1'b0, 1'b0); post_edge(); end
    tests_run++; if (wptr !== 4'd14) begin tests_failed++; $display("FAIL wrap_start: got %0d expected 14", wptr); end
    for (int i = 0; i < 4; i++) begin
      pre_edge(1'b1, 1'b0, 1'b0);
      tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL wrap_we[%0d]: got %0b expected 1", i, mem_we); end
      tests_run++; if (mem_waddr !== AW'(exp_addr[i])) begin tests_failed++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, mem_waddr, exp_addr[i]); end
      post_edge();
    end
    tests_run++; if (wptr !== 4'd2) begin tests_failed++; $display("FAIL wrap_wptr: got %0d expected 2", wptr); end
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL wrap_full: got %0b expected 1", full); end
    tests_run++; if (fill_level !== 4'd15) begin tests_failed++; $display("FAIL wrap_level: got %0d expected 15", fill_level); end
  endtask

  task automatic test_rw_full();
    pre_edge(1'b1, 1'b1, 1'b0);
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rwfull_we: got %0b expected 0", mem_we); end
    post_edge();
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL rwfull_ovf: got %0b expected 1", overflow); end
    pre_edge(1'b1, 1'b0, 1'b0);
    tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL rwfull_retry_we: got %0b expected 1", mem_we); end
    tests_run++; if (mem_waddr !== 4'd2) begin tests_failed++; $display("FAIL rwfull_retry_addr: got %0d expected 2", mem_waddr); end
    post_edge();
    tests_run++; if (wptr !== 4'd3) begin tests_failed++; $display("FAIL rwfull_wptr: got %0d expected 3", wptr); end
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL rwfull_full: got %0b expected 1", full); end
  endtask

  task automatic test_set_wins();
    pre_edge(1'b0, 1'b0, 1'b1);
    post_edge();
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL setwins_pre: got %0b expected 0", overflow); end
    pre_edge(1'b1, 1'b0, 1'b1);
    post_edge();
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL setwins: got %0b expected 1", overflow); end
  endtask

  task automatic test_soak();
    bit wr, rd, clr;
    int exp_lvl;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      // Alternate write-heavy and read-heavy phases to visit full and empty.
      if ((n / 100) % 2 == 0) begin
        wr = ($urandom_range(0, 99) < 80); rd = ($urandom_range(0, 99) < 35);
      end else begin
        wr = ($urandom_range(0, 99) < 35); rd = ($urandom_range(0, 99) < 80);
      end
      clr = ($urandom_range(0, 15) == 0);
      pre_edge(wr, rd, clr);
      exp_lvl = q.size();
      tests_run++; if (fill_level !== AW'(exp_lvl)) begin tests_failed++; $display("FAIL soak_level[%0d]: got %0d expected %0d", n, fill_level, exp_lvl); end
      tests_run++; if (full !== (exp_lvl == CAP)) begin tests_failed++; $display("FAIL soak_full[%0d]: got %0b expected %0b", n, full, (exp_lvl == CAP)); end
      tests_run++; if (mem_we !== (wr && exp_lvl != CAP)) begin tests_failed++; $display("FAIL soak_we[%0d]: got %0b expected %0b", n, mem_we, (wr && exp_lvl != CAP)); end
      tests_run++; if (mem_waddr !== AW'(wp_m)) begin tests_failed++; $display("FAIL soak_addr[%0d]: got %0d expected %0d", n, mem_waddr, wp_m); end
      post_edge();
      tests_run++; if (wptr !== AW'(wp_m)) begin tests_failed++; $display("FAIL soak_wptr[%0d]: got %0d expected %0d", n, wptr, wp_m); end
      tests_run++; if (overflow !== ovf_m) begin tests_failed++; $display("FAIL soak_ovf[%0d]: got %0b expected %0b", n, overflow, ovf_m); end
      tests_run++; if (almost_full !== af_m) begin tests_failed++; $display("FAIL soak_af[%0d]: got %0b expected %0b", n, almost_full, af_m); end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    rptr    = '0;
    rd_req  = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
    test_rw_full();
    test_set_wins();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
